// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: turns the UART receiver byte stream into SOF/LEN/payload/CHK
// frames, buffers the payload, verifies the XOR checksum and holds each good
// frame for a valid/ready consumer that reads the payload by address.
module uart_frame_ctrl #(
    parameter logic [7:0] SOF            = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 34720
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic [4:0] frame_len,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       err_len,
    output logic       err_chk,
    output logic       err_timeout,
    output logic       err_overrun
);

    localparam int              TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]      MAX_LEN_B  = 8'(MAX_LEN);
    localparam logic [TW-1:0]   TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        HUNT,
        GET_LEN,
        GET_PAYLOAD,
        GET_CHK,
        HOLD
    } state_t;

    state_t        state, state_nxt;
    logic [4:0]    len_nxt;
    logic [7:0]    chk, chk_nxt;
    logic [3:0]    idx, idx_nxt;
    logic [TW-1:0] tmo_cnt, tmo_nxt;
    logic          err_len_nxt, err_chk_nxt, err_timeout_nxt, err_overrun_nxt;
    logic          buf_we;
    logic [7:0]    frame_buf [MAX_LEN];

    // Next-state, datapath updates and error pulses for the framing FSM.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a variable unassigned (latch).
        state_nxt       = state;
        len_nxt         = frame_len;
        chk_nxt         = chk;
        idx_nxt         = idx;
        tmo_nxt         = '0;
        err_len_nxt     = 1'b0;
        err_chk_nxt     = 1'b0;
        err_timeout_nxt = 1'b0;
        err_overrun_nxt = 1'b0;
        buf_we          = 1'b0;

        // Inter-byte watchdog: only runs while a frame is partially received.
        if (state == GET_LEN || state == GET_PAYLOAD || state == GET_CHK) begin
            if (byte_valid) begin
                tmo_nxt = '0;
            end else if (tmo_cnt == TMO_LAST) begin
                tmo_nxt         = '0;
                err_timeout_nxt = 1'b1;
                state_nxt       = HUNT;
            end else begin
                tmo_nxt = tmo_cnt + 1'b1;
            end
        end

        case (state)
            HUNT: begin
                if (byte_valid && byte_data == SOF) begin
                    state_nxt = GET_LEN;
                    chk_nxt   = '0;
                end
            end
            GET_LEN: begin
                if (byte_valid) begin
                    if (byte_data == 8'd0 || byte_data > MAX_LEN_B) begin
                        err_len_nxt = 1'b1;
                        state_nxt   = HUNT;
                    end else begin
                        len_nxt   = byte_data[4:0];
                        chk_nxt   = byte_data;
                        idx_nxt   = '0;
                        state_nxt = GET_PAYLOAD;
                    end
                end
            end
            GET_PAYLOAD: begin
                if (byte_valid) begin
                    buf_we  = 1'b1;
                    chk_nxt = chk ^ byte_data;
                    if ({1'b0, idx} == frame_len - 5'd1) begin
                        state_nxt = GET_CHK;
                    end else begin
                        idx_nxt = idx + 4'd1;
                    end
                end
            end
            GET_CHK: begin
                if (byte_valid) begin
                    if (byte_data == chk) begin
                        state_nxt = HOLD;
                    end else begin
                        err_chk_nxt = 1'b1;
                        state_nxt   = HUNT;
                    end
                end
            end
            HOLD: begin
                // The single buffer is occupied: any incoming byte is lost.
                err_overrun_nxt = byte_valid;
                if (frame_valid && frame_ready) begin
                    state_nxt = HUNT;
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    // State, control registers and registered status/error outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            frame_len   <= '0;
            chk         <= '0;
            idx         <= '0;
            tmo_cnt     <= '0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
            err_len     <= 1'b0;
            err_chk     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values computed above, independent of statement order.
            state       <= state_nxt;
            frame_len   <= len_nxt;
            chk         <= chk_nxt;
            idx         <= idx_nxt;
            tmo_cnt     <= tmo_nxt;
            frame_valid <= (state_nxt == HOLD);
            busy        <= (state_nxt != HUNT);
            err_len     <= err_len_nxt;
            err_chk     <= err_chk_nxt;
            err_timeout <= err_timeout_nxt;
            err_overrun <= err_overrun_nxt;
        end
    end

    // Payload buffer write port; written only while collecting payload.
    always_ff @(posedge clk) begin
        // NOTE: the buffer has no reset; its contents are meaningless until a
        // frame is written, and leaving it unreset lets it map onto plain RAM.
        if (buf_we) begin
            frame_buf[idx] <= byte_data;
        end
    end

    assign rd_data = frame_buf[rd_addr];

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed testbench for uart_frame_ctrl: good frames, length/checksum errors,
// inter-byte timeout, overrun while holding, and reset mid-frame.
module tb_uart_frame_ctrl;

    localparam int TMO = 34720;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_valid;
    logic       frame_ready;
    logic [4:0] frame_len;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic       err_len;
    logic       err_chk;
    logic       err_timeout;
    logic       err_overrun;

    int checks   = 0;
    int failures = 0;

    uart_frame_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_len   (frame_len),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .busy        (busy),
        .err_len     (err_len),
        .err_chk     (err_chk),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Called at a negedge; presents one byte for the next posedge, returns at the following negedge.
    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        rd_addr = a;
        #1;
        check(tag, rd_data, exp);
    endtask

    // Accept the held frame with a one-cycle frame_ready pulse.
    task automatic release_frame();
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
    endtask

    logic [7:0] big [16];
    logic [7:0] big_chk;

    initial begin
        rst_n       = 1'b0;
        byte_valid  = 1'b0;
        byte_data   = 8'h00;
        frame_ready = 1'b0;
        rd_addr     = 4'd0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_frame_valid", frame_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_len", frame_len, 0);
        check("rst_errs", {err_len, err_chk, err_timeout, err_overrun}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Good frame A5 03 01 02 03 03
        send_byte(8'hA5);
        check("good_busy_after_sof", busy, 1);
        send_byte(8'h03);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        check("good_not_valid_before_chk", frame_valid, 0);
        send_byte(8'h03);
        check("good_frame_valid", frame_valid, 1);
        check("good_frame_len", frame_len, 3);
        check("good_no_err", {err_len, err_chk, err_timeout, err_overrun}, 0);
        read_chk("good_rd0", 4'd0, 8'h01);
        read_chk("good_rd1", 4'd1, 8'h02);
        read_chk("good_rd2", 4'd2, 8'h03);
        @(negedge clk);
        check("good_valid_stays", frame_valid, 1);
        release_frame();
        check("good_released_valid", frame_valid, 0);
        check("good_released_busy", busy, 0);

        // Hunt: junk ignored, then LEN=0 and LEN=17 errors
        send_byte(8'h00);
        check("hunt_00_busy", busy, 0);
        send_byte(8'hFF);
        check("hunt_ff_busy", busy, 0);
        send_byte(8'hA5);
        send_byte(8'h00);
        check("len0_err", err_len, 1);
        check("len0_busy", busy, 0);
        @(negedge clk);
        check("len0_pulse_one_cycle", err_len, 0);
        send_byte(8'hA5);
        send_byte(8'h11);
        check("len17_err", err_len, 1);
        @(negedge clk);

        // Checksum error: A5 02 10 20 00 (expected 32)
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h00);
        check("chk_err", err_chk, 1);
        check("chk_err_no_valid", frame_valid, 0);
        @(negedge clk);
        check("chk_err_one_cycle", err_chk, 0);

        // Good one-byte frame A5 01 7E 7F, then overrun while holding
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h7E);
        send_byte(8'h7F);
        check("len1_valid", frame_valid, 1);
        check("len1_frame_len", frame_len, 1);
        send_byte(8'h55);
        check("ovr_err", err_overrun, 1);
        check("ovr_still_valid", frame_valid, 1);
        read_chk("ovr_buf_unchanged", 4'd0, 8'h7E);
        @(negedge clk);
        check("ovr_one_cycle", err_overrun, 0);
        // byte on the handshake cycle is dropped, not taken as SOF
        frame_ready = 1'b1;
        send_byte(8'hA5);
        frame_ready = 1'b0;
        check("ovr_hs_err", err_overrun, 1);
        check("ovr_hs_valid", frame_valid, 0);
        check("ovr_hs_busy", busy, 0);

        // Maximum-length frame (16 bytes)
        big_chk = 8'd16;
        for (int i = 0; i < 16; i++) begin
            big[i]  = 8'(i * 37 + 5);
            big_chk = big_chk ^ big[i];
        end
        send_byte(8'hA5);
        send_byte(8'd16);
        for (int i = 0; i < 16; i++) send_byte(big[i]);
        send_byte(big_chk);
        check("max_valid", frame_valid, 1);
        check("max_len", frame_len, 16);
        read_chk("max_rd0", 4'd0, big[0]);
        read_chk("max_rd9", 4'd9, big[9]);
        read_chk("max_rd15", 4'd15, big[15]);
        release_frame();

        // Timeout: A5 04 AA then silence
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'hAA);
        repeat (TMO - 1) @(negedge clk);
        check("tmo_not_early", err_timeout, 0);
        check("tmo_busy_before", busy, 1);
        @(negedge clk);
        check("tmo_fire", err_timeout, 1);
        check("tmo_busy_after", busy, 0);
        @(negedge clk);
        check("tmo_one_cycle", err_timeout, 0);

        // Byte on the last allowed cycle keeps the frame alive
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'hAA);
        repeat (TMO - 1) @(negedge clk);
        send_byte(8'hBB);
        check("tmo_edge_no_err", err_timeout, 0);
        check("tmo_edge_busy", busy, 1);
        send_byte(8'hCC);
        send_byte(8'hDD);
        send_byte(8'h04);
        check("tmo_edge_valid", frame_valid, 1);
        read_chk("tmo_edge_rd1", 4'd1, 8'hBB);
        release_frame();

        // Reset mid-payload discards the frame silently
        send_byte(8'hA5);
        send_byte(8'h05);
        send_byte(8'h11);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_len", frame_len, 0);
        check("midrst_errs", {err_len, err_chk, err_timeout, err_overrun}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h44);
        send_byte(8'h45);
        check("midrst_next_valid", frame_valid, 1);
        read_chk("midrst_next_rd0", 4'd0, 8'h44);
        release_frame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
